// File: rtl/hdmi_packet_pkg.sv
// rtl/hdmi_packet_pkg.sv - HDMI data-island packet constants, subpacket type and BCH step
package hdmi_packet_pkg;

    localparam int PACKET_PIXELS = 32;
    localparam int HEADER_BITS = 24;
    localparam int SUB_BITS = 56;
    localparam logic [7:0] BCH_POLY = 8'h83;

    typedef logic [SUB_BITS-1:0] subpacket_t;

    // One LSB-first serial step of G(x)=1+x^6+x^7+x^8.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic d);
        return (ecc >> 1) ^ (((ecc[0] ^ d) == 1'b1) ? BCH_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/packet_assembler_if.sv
// rtl/packet_assembler_if.sv - generator-side inputs and TERC4-side outputs of the packet assembler
interface packet_assembler_if;
    import hdmi_packet_pkg::*;

    logic                    data_island_period;
    logic [HEADER_BITS-1:0]  header;
    subpacket_t [3:0]        sub;
    logic [8:0]              packet_data;
    logic                    packet_data_valid;
    logic [4:0]              counter;
    logic                    packet_enable;
    logic [7:0]              abort_count;

    modport master (
        output data_island_period, header, sub,
        input  packet_data, packet_data_valid, counter, packet_enable, abort_count
    );

    modport slave (
        input  data_island_period, header, sub,
        output packet_data, packet_data_valid, counter, packet_enable, abort_count
    );

endinterface

// File: rtl/bch_ecc_lane.sv
// rtl/bch_ecc_lane.sv - 8-bit BCH ECC register with clear and STEPS serial steps per cycle
module bch_ecc_lane
    import hdmi_packet_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             clear,
    input  logic             step_en,
    input  logic [STEPS-1:0] din,
    output logic [7:0]       ecc
);

    logic [7:0] ecc_next;

    // Clear happens before the first step so a packet start clears and steps in one cycle.
    always_comb begin
        ecc_next = clear ? 8'h00 : ecc;
        if (step_en) begin
            for (int s = 0; s < STEPS; s++) begin
                ecc_next = bch_step(ecc_next, din[s]);
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            ecc <= 8'h00;
        end else if (clear || step_en) begin
            ecc <= ecc_next;
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// rtl/packet_assembler.sv - serialises header + 4 subpackets into a 32-pixel data-island packet with BCH ECC
// Optional aborted-packet counter: PACKET_ASSEMBLER_ABORT_COUNT_EN
module packet_assembler
    import hdmi_packet_pkg::*;
(
    input  logic                clk_pixel,
    input  logic                reset,
    packet_assembler_if.slave   bus
);

    localparam logic [4:0] HDR_PIX = 5'(HEADER_BITS);
    localparam logic [4:0] SUB_PIX = 5'(SUB_BITS / 2);
    localparam logic [4:0] LAST_K  = 5'(PACKET_PIXELS - 1);

    logic [4:0]             k;
    logic [HEADER_BITS-1:0] hdr_snap;
    subpacket_t [3:0]       sub_snap;
    logic [HEADER_BITS-1:0] hdr_cur;
    subpacket_t [3:0]       sub_cur;

    logic       start;
    logic       abort;
    logic [7:0] hecc;
    logic [7:0] secc [4];
    logic [1:0] sub_din [4];
    logic       ch0;
    logic [3:0] ch1;
    logic [3:0] ch2;

    assign start = bus.data_island_period && (k == 5'd0);
    assign abort = !bus.data_island_period && (k != 5'd0);

    // Pixel 0 reads the live inputs; later pixels only see the snapshot.
    always_comb begin
        hdr_cur = (k == 5'd0) ? bus.header : hdr_snap;
        sub_cur = (k == 5'd0) ? bus.sub : sub_snap;
        ch0 = (k < HDR_PIX) ? hdr_cur[k] : hecc[k[2:0]];
        ch1 = 4'h0;
        ch2 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sub_din[i] = {sub_cur[i][{k, 1'b1}], sub_cur[i][{k, 1'b0}]};
            if (k < SUB_PIX) begin
                ch1[i] = sub_din[i][0];
                ch2[i] = sub_din[i][1];
            end else begin
                ch1[i] = secc[i][{k[1:0], 1'b0}];
                ch2[i] = secc[i][{k[1:0], 1'b1}];
            end
        end
    end

    bch_ecc_lane #(.STEPS(1)) u_hdr_ecc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .clear     (start || abort),
        .step_en   (bus.data_island_period && (k < HDR_PIX)),
        .din       (hdr_cur[k]),
        .ecc       (hecc)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sub_ecc
        bch_ecc_lane #(.STEPS(2)) u_sub_ecc (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .clear     (start || abort),
            .step_en   (bus.data_island_period && (k < SUB_PIX)),
            .din       (sub_din[g]),
            .ecc       (secc[g])
        );
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            k                     <= 5'd0;
            hdr_snap              <= '0;
            sub_snap              <= '0;
            bus.packet_data       <= 9'h000;
            bus.packet_data_valid <= 1'b0;
            bus.counter           <= 5'd0;
            bus.packet_enable     <= 1'b0;
        end else if (bus.data_island_period) begin
            if (start) begin
                hdr_snap <= bus.header;
                sub_snap <= bus.sub;
            end
            k                     <= k + 5'd1;
            bus.packet_data       <= {ch2, ch1, ch0};
            bus.packet_data_valid <= 1'b1;
            bus.counter           <= k;
            bus.packet_enable     <= (k == LAST_K);
        end else begin
            k                     <= 5'd0;
            bus.packet_data       <= 9'h000;
            bus.packet_data_valid <= 1'b0;
            bus.counter           <= 5'd0;
            bus.packet_enable     <= 1'b0;
        end
    end

`ifdef PACKET_ASSEMBLER_ABORT_COUNT_EN
    logic [7:0] abort_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            abort_q <= 8'h00;
        end else if (abort && (abort_q != 8'hFF)) begin
            abort_q <= abort_q + 8'h01;
        end
    end

    assign bus.abort_count = abort_q;
`else
    assign bus.abort_count = 8'h00;
`endif

endmodule

// File: tb/tb_packet_assembler.sv
// tb/tb_packet_assembler.sv - randomized scoreboard bench for packet_assembler against a packet-level model
module tb_packet_assembler;
    import hdmi_packet_pkg::*;

    typedef logic [3:0][55:0] subs_t;
    typedef struct packed {
        logic [8:0] d;
        logic [4:0] c;
        logic       en;
    } exp_t;

    logic clk_pixel = 1'b0;
    logic reset = 1'b1;

    packet_assembler_if bus();

    packet_assembler dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_cyc[$];
    logic [39:0] obs_ecc[$];
    logic [8:0]  obs[32];
    logic [8:0]  exp_pix[32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Remainder of the bit stream (LSB first) divided by 1+x^6+x^7+x^8.
    function automatic logic [7:0] ref_ecc(input logic [63:0] bits, input int n);
        logic [7:0] e = 8'h00;
        logic       fb;
        for (int j = 0; j < n; j++) begin
            fb = e[0] ^ bits[j];
            e = e >> 1;
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    task automatic build_model(input logic [23:0] h, input subs_t s);
        logic [31:0] hl;
        logic [63:0] sl [4];
        hl = {ref_ecc({40'b0, h}, 24), h};
        for (int i = 0; i < 4; i++) sl[i] = {ref_ecc({8'b0, s[i]}, 56), s[i]};
        for (int p = 0; p < 32; p++) begin
            exp_pix[p][0] = hl[p];
            for (int i = 0; i < 4; i++) begin
                exp_pix[p][1 + i] = sl[i][2 * p];
                exp_pix[p][5 + i] = sl[i][2 * p + 1];
            end
        end
    endtask

    function automatic subs_t rand_sub();
        subs_t s;
        for (int i = 0; i < 4; i++) s[i] = {$urandom(), $urandom()} & 64'h00FF_FFFF_FFFF_FFFF;
        return s;
    endfunction

    function automatic logic [39:0] ecc_of_obs();
        logic [39:0] r = '0;
        for (int j = 0; j < 8; j++) r[j] = obs[24 + j][0];
        for (int i = 0; i < 4; i++) begin
            for (int m = 0; m < 4; m++) begin
                r[8 + 8 * i + 2 * m]     = obs[28 + m][1 + i];
                r[8 + 8 * i + 2 * m + 1] = obs[28 + m][5 + i];
            end
        end
        return r;
    endfunction

    task automatic run_packet(input logic [23:0] h, input subs_t s, input int npix, input int change_at);
        exp_t e;
        build_model(h, s);
        for (int p = 0; p < npix; p++) begin
            bus.data_island_period = 1'b1;
            if (p == 0) begin
                bus.header = h;
                bus.sub = s;
            end
            if (p == change_at) begin
                bus.header = 24'($urandom());
                bus.sub = rand_sub();
            end
            e.d = exp_pix[p];
            e.c = 5'(p);
            e.en = (p == 31);
            sb.push_back(e);
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic idle(input int n);
        bus.data_island_period = 1'b0;
        repeat (n) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    always @(negedge clk_pixel) begin
        exp_t e;
        cyc++;
        if (bus.packet_data_valid === 1'b1) begin
            obs[bus.counter] = bus.packet_data;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got counter=%0d, expected no valid output", bus.counter);
            end else begin
                e = sb.pop_front();
                checks++;
                if ({bus.packet_data, bus.counter, bus.packet_enable} !== e) begin
                    errors++;
                    $display("FAIL pixel: got data=%h cnt=%0d en=%b, expected data=%h cnt=%0d en=%b",
                             bus.packet_data, bus.counter, bus.packet_enable, e.d, e.c, e.en);
                end
            end
            if (bus.packet_enable === 1'b1) begin
                en_cyc.push_back(cyc);
                obs_ecc.push_back(ecc_of_obs());
            end
        end else begin
            check("idle_outputs", {bus.packet_data, bus.counter, bus.packet_enable}, 64'h0);
        end
    end

    initial begin
        logic [23:0] ha, hb;
        subs_t       sa, sbv;
        logic [7:0]  exp_abort;

        bus.data_island_period = 1'b0;
        bus.header = '0;
        bus.sub = '0;
        repeat (2) @(posedge clk_pixel);
        #1;
        check("reset_data", bus.packet_data, 0);
        check("reset_valid", bus.packet_data_valid, 0);
        check("reset_abort_count", bus.abort_count, 0);
        reset = 1'b0;
        idle(2);

        // all-zero packet
        en_cyc.delete();
        run_packet(24'h0, '0, 32, -1);
        idle(2);
        check("t1_enable_pulses", en_cyc.size(), 1);

        // single-bit header and subpacket 0
        run_packet(24'h000001, subs_t'(56'h1), 32, -1);
        idle(2);
        check("t2_ch0_k0", obs[0][0], 1);
        check("t2_ch1_0_k0", obs[0][1], 1);

        // ECC linearity on all five lanes
        ha = 24'($urandom());
        hb = 24'($urandom());
        sa = rand_sub();
        sbv = rand_sub();
        obs_ecc.delete();
        run_packet(ha, sa, 32, -1);
        run_packet(hb, sbv, 32, -1);
        run_packet(ha ^ hb, sa ^ sbv, 32, -1);
        idle(2);
        check("t3_packets_seen", obs_ecc.size(), 3);
        if (obs_ecc.size() == 3) begin
            for (int l = 0; l < 5; l++) begin
                check($sformatf("t3_linear_lane%0d", l), obs_ecc[2][8 * l +: 8],
                      obs_ecc[0][8 * l +: 8] ^ obs_ecc[1][8 * l +: 8]);
            end
        end

        // inputs change mid-packet
        run_packet(24'($urandom()), rand_sub(), 32, 5);
        idle(1);

        // abort at k=17
        en_cyc.delete();
        run_packet(24'($urandom()), rand_sub(), 17, -1);
        idle(1);
        check("t5_valid_after_abort", bus.packet_data_valid, 0);
        check("t5_data_after_abort", bus.packet_data, 0);
`ifdef PACKET_ASSEMBLER_ABORT_COUNT_EN
        exp_abort = 8'd1;
`else
        exp_abort = 8'd0;
`endif
        check("t5_abort_count", bus.abort_count, exp_abort);
        idle(2);
        check("t5_no_enable", en_cyc.size(), 0);
        run_packet(24'($urandom()), rand_sub(), 32, -1);
        idle(2);
        check("t5_next_packet_enable", en_cyc.size(), 1);

        // random packets with random gaps
        for (int n = 0; n < 6; n++) begin
            run_packet(24'($urandom()), rand_sub(), 32, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        // back-to-back packets, then reset mid-packet
        en_cyc.delete();
        run_packet(24'($urandom()), rand_sub(), 32, -1);
        run_packet(24'($urandom()), rand_sub(), 32, -1);
        idle(2);
        check("t6_enable_pulses", en_cyc.size(), 2);
        if (en_cyc.size() == 2) check("t6_enable_spacing", en_cyc[1] - en_cyc[0], 32);
        run_packet(24'($urandom()), rand_sub(), 10, -1);
        reset = 1'b1;
        @(posedge clk_pixel);
        #1;
        check("t6_reset_data", bus.packet_data, 0);
        check("t6_reset_valid", bus.packet_data_valid, 0);
        check("t6_reset_counter", bus.counter, 0);
        check("t6_reset_enable", bus.packet_enable, 0);
        check("t6_reset_abort_count", bus.abort_count, 0);
        reset = 1'b0;
        idle(3);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
